demux_stream_1_to_n: RTL and testbench

DEMUX_STREAM_1_TO_N -- requirements
Module: demux_stream_1_to_n

---
 rtl/demux_stream_1_to_n_pkg.sv | 31 +++
 rtl/demux_stream_1_to_n_if.sv | 62 ++++++
 rtl/demux_stream_1_to_n_ch_slot.sv | 54 +++++
 rtl/demux_stream_1_to_n.sv | 137 +++++++++++++
 tb/tb_demux_stream_1_to_n.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_stream_1_to_n_pkg.sv
// -----------------------------------------------------------------------------
// demux_stream_1_to_n_pkg
//
// Purpose : shared constants, types and helpers for the 1-to-N stream
//           demultiplexer (top, channel slot and bus interface).
//
// Contents:
//   CNN_DATA_WIDTH - default bits per data word
//   CNN_NUM_CH     - default number of output channels
//   route_mode_e   - routing mode encoding carried on the 'mode' input
//   ch_idx_w(n)    - width of a channel index able to address n channels
// -----------------------------------------------------------------------------
package demux_stream_1_to_n_pkg;

    localparam int CNN_DATA_WIDTH = 7;
    localparam int CNN_NUM_CH     = 29;

    // Addressed mode routes by the sel input; sequential mode routes by the
    // internal round-robin pointer.
    typedef enum logic {
        MODE_ADDR = 1'b0,
        MODE_SEQ  = 1'b1
    } route_mode_e;

    // Select width for n channels. Never returns 0 so that a select port
    // always has at least one bit, even for degenerate channel counts.
    function automatic int ch_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_stream_1_to_n_if.sv
// -----------------------------------------------------------------------------
// demux_stream_1_to_n_if
//
// Purpose : bundles the upstream stream (in_valid/in_ready/din/sel) and the
//           per-channel downstream streams (out_valid/out_ready/dout) of the
//           demultiplexer.
//
// Handshake: every stream uses strict valid/ready semantics. A word moves
//           on a rising clock edge where valid and ready are both 1. The
//           producer must not make valid depend on ready; once valid is
//           raised the word and its attributes stay stable until it moves.
//
// Signals :
//   in_valid  - upstream word available
//   in_ready  - demultiplexer accepts the upstream word this cycle
//   din       - upstream data word (DATA_WIDTH)
//   sel       - target channel in addressed mode (SEL_WIDTH)
//   dout      - flat output bus, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid - per-channel valid (NUM_CH)
//   out_ready - per-channel ready from the consumers (NUM_CH)
//
// Modports:
//   slave  - the demultiplexer itself
//   master - the environment: upstream producer plus downstream consumers
// -----------------------------------------------------------------------------
interface demux_stream_1_to_n_if
    import demux_stream_1_to_n_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int NUM_CH     = CNN_NUM_CH,
    parameter int SEL_WIDTH  = ch_idx_w(NUM_CH)
);

    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_WIDTH-1:0]        din;
    logic [SEL_WIDTH-1:0]         sel;
    logic [NUM_CH*DATA_WIDTH-1:0] dout;
    logic [NUM_CH-1:0]            out_valid;
    logic [NUM_CH-1:0]            out_ready;

    modport slave (
        input  in_valid,
        input  din,
        input  sel,
        input  out_ready,
        output in_ready,
        output dout,
        output out_valid
    );

    modport master (
        output in_valid,
        output din,
        output sel,
        output out_ready,
        input  in_ready,
        input  dout,
        input  out_valid
    );

endinterface

// File: rtl/demux_stream_1_to_n_ch_slot.sv
// -----------------------------------------------------------------------------
// demux_ch_slot
//
// Purpose : one output channel of the demultiplexer: a single-entry register
//           holding a data word and its valid flag.
//
// Ports   :
//   clk, reset_n - clock and asynchronous active-low reset
//   i_load       - write i_din into the slot on this edge (sets valid)
//   i_din        - word to load
//   i_ready      - downstream consumer ready for this channel
//   o_valid      - slot holds a word
//   o_data       - held word (stable while o_valid=1 and i_ready=0)
//
// Load has priority over drain, so a word leaving and a new word arriving on
// the same edge keeps the slot full and sustains one word per cycle.
// -----------------------------------------------------------------------------
module demux_ch_slot
    import demux_stream_1_to_n_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_load) begin
                r_valid <= 1'b1;
                r_data  <= i_din;
            end else if (r_valid && i_ready) begin
                // Word handed to the consumer; data is left in place since
                // it is don't-care while invalid.
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/demux_stream_1_to_n.sv
// -----------------------------------------------------------------------------
// demux_stream_1_to_n
//
// Purpose : routes a single valid/ready input stream to one of NUM_CH output
//           streams. The target channel comes either from the sel input
//           (addressed mode) or from an internal pointer that advances on
//           every accepted word (sequential mode).
//
// Ports   :
//   clk        - clock, all state changes on the rising edge
//   reset_n    - asynchronous active-low reset
//   mode       - 0: route by sel, 1: route by ptr (takes effect immediately)
//   start      - synchronous pulse clearing ptr; blocks input that cycle
//   bus        - stream interface (slave side): in_valid/in_ready/din/sel
//                upstream, out_valid/out_ready/dout downstream
//   ptr        - current sequential pointer
//   round_done - one-cycle pulse in the cycle after ptr wraps to 0
//   sel_err    - one-cycle pulse in the cycle after an out-of-range sel word
//                was accepted (and dropped)
//
// Each channel is a one-entry slot (demux_ch_slot). The input is ready when
// the target slot is empty or is being drained this cycle, so a channel
// whose consumer is always ready sustains one word per cycle. A word
// addressed outside the channel range is swallowed so it cannot stall the
// upstream producer.
// -----------------------------------------------------------------------------
module demux_stream_1_to_n
    import demux_stream_1_to_n_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int NUM_CH     = CNN_NUM_CH,
    parameter int SEL_WIDTH  = ch_idx_w(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mode,
    input  logic                  start,
    demux_stream_1_to_n_if.slave  bus,
    output logic [SEL_WIDTH-1:0]  ptr,
    output logic                  round_done,
    output logic                  sel_err
);

    // Channel count widened by one bit so the range check also works when
    // NUM_CH is a power of two (e.g. 64 channels with a 6-bit select).
    localparam logic [SEL_WIDTH:0]   LP_NUM_CH  = (SEL_WIDTH+1)'(NUM_CH);
    localparam logic [SEL_WIDTH-1:0] LP_LAST_CH = SEL_WIDTH'(NUM_CH - 1);

    logic [SEL_WIDTH-1:0]         r_ptr;
    logic                         r_round_done;
    logic                         r_sel_err;

    logic [SEL_WIDTH-1:0]         w_tgt;
    logic                         w_tgt_legal;
    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_seq_mode;
    logic                         w_wrap;
    logic [NUM_CH-1:0]            w_load;
    logic [NUM_CH-1:0]            w_out_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] w_dout;

    // -------------------------------------------------------------------------
    // Target selection and input acceptance
    // -------------------------------------------------------------------------
    always_comb begin
        w_seq_mode  = (mode == MODE_SEQ);
        w_tgt       = w_seq_mode ? r_ptr : bus.sel;
        w_tgt_legal = ({1'b0, w_tgt} < LP_NUM_CH);

        w_in_ready = 1'b0;
        if (!reset_n || start) begin
            // Held off during reset and on the pointer-clear cycle so that
            // no word can be routed by a pointer that is about to change.
            w_in_ready = 1'b0;
        end else if (!w_tgt_legal) begin
            w_in_ready = 1'b1;
        end else begin
            w_in_ready = !w_out_valid[w_tgt] || bus.out_ready[w_tgt];
        end

        w_accept = bus.in_valid && w_in_ready;
        w_wrap   = w_accept && w_seq_mode && (r_ptr == LP_LAST_CH);
    end

    // -------------------------------------------------------------------------
    // Sequential pointer and status pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr        <= '0;
            r_round_done <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_round_done <= w_wrap;
            r_sel_err    <= w_accept && !w_tgt_legal;
            if (start) begin
                r_ptr <= '0;
            end else if (w_accept && w_seq_mode) begin
                r_ptr <= w_wrap ? '0 : r_ptr + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Channel slots
    // -------------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_slot
            assign w_load[g] = w_accept && w_tgt_legal && (w_tgt == SEL_WIDTH'(g));

            demux_ch_slot #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_slot (
                .clk     (clk),
                .reset_n (reset_n),
                .i_load  (w_load[g]),
                .i_din   (bus.din),
                .i_ready (bus.out_ready[g]),
                .o_valid (w_out_valid[g]),
                .o_data  (w_dout[g*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.dout      = w_dout;
    assign ptr           = r_ptr;
    assign round_done    = r_round_done;
    assign sel_err       = r_sel_err;

endmodule

// File: tb/tb_demux_stream_1_to_n.sv
// -----------------------------------------------------------------------------
// tb_demux_stream_1_to_n
//
// Bench for demux_stream_1_to_n. Three instances share clock and reset:
//   a - default parameters (DATA_WIDTH=7, NUM_CH=29)
//   b - DATA_WIDTH=16, NUM_CH=4
//   c - DATA_WIDTH=7,  NUM_CH=2
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_demux_stream_1_to_n;
    import demux_stream_1_to_n_pkg::*;

    localparam int DW_A = CNN_DATA_WIDTH;
    localparam int N_A  = CNN_NUM_CH;
    localparam int SW_A = ch_idx_w(N_A);
    localparam int DW_B = 16;
    localparam int N_B  = 4;
    localparam int SW_B = ch_idx_w(N_B);
    localparam int DW_C = CNN_DATA_WIDTH;
    localparam int N_C  = 2;
    localparam int SW_C = ch_idx_w(N_C);

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance a ----------------
    demux_stream_1_to_n_if #(.DATA_WIDTH(DW_A), .NUM_CH(N_A), .SEL_WIDTH(SW_A)) bus_a ();
    logic            mode_a, start_a, round_done_a, sel_err_a;
    logic [SW_A-1:0] ptr_a;
    demux_stream_1_to_n #(.DATA_WIDTH(DW_A), .NUM_CH(N_A), .SEL_WIDTH(SW_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .mode(mode_a), .start(start_a), .bus(bus_a),
        .ptr(ptr_a), .round_done(round_done_a), .sel_err(sel_err_a)
    );

    // ---------------- instance b ----------------
    demux_stream_1_to_n_if #(.DATA_WIDTH(DW_B), .NUM_CH(N_B), .SEL_WIDTH(SW_B)) bus_b ();
    logic            mode_b, start_b, round_done_b, sel_err_b;
    logic [SW_B-1:0] ptr_b;
    demux_stream_1_to_n #(.DATA_WIDTH(DW_B), .NUM_CH(N_B), .SEL_WIDTH(SW_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .mode(mode_b), .start(start_b), .bus(bus_b),
        .ptr(ptr_b), .round_done(round_done_b), .sel_err(sel_err_b)
    );

    // ---------------- instance c ----------------
    demux_stream_1_to_n_if #(.DATA_WIDTH(DW_C), .NUM_CH(N_C), .SEL_WIDTH(SW_C)) bus_c ();
    logic            mode_c, start_c, round_done_c, sel_err_c;
    logic [SW_C-1:0] ptr_c;
    demux_stream_1_to_n #(.DATA_WIDTH(DW_C), .NUM_CH(N_C), .SEL_WIDTH(SW_C)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .mode(mode_c), .start(start_c), .bus(bus_c),
        .ptr(ptr_c), .round_done(round_done_c), .sel_err(sel_err_c)
    );

    // ---------------- driver ----------------
    task automatic idle_all();
        mode_a = 1'b0; start_a = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.din = '0; bus_a.sel = '0; bus_a.out_ready = '1;
        mode_b = 1'b0; start_b = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.din = '0; bus_b.sel = '0; bus_b.out_ready = '1;
        mode_c = 1'b0; start_c = 1'b0;
        bus_c.in_valid = 1'b0; bus_c.din = '0; bus_c.sel = '0; bus_c.out_ready = '1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        idle_all();
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus_a.in_ready); end
        n_tests++; if (bus_a.out_valid !== '0) begin n_fail++; $display("FAIL reset_out_valid: got %h expected 0", bus_a.out_valid); end
        n_tests++; if (bus_a.dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", bus_a.dout); end
        n_tests++; if (ptr_a !== '0) begin n_fail++; $display("FAIL reset_ptr: got %0d expected 0", ptr_a); end
        n_tests++; if (round_done_a !== 1'b0 || sel_err_a !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got rd=%b se=%b expected 0 0", round_done_a, sel_err_a); end
        n_tests++; if (bus_b.out_valid !== '0 || bus_c.out_valid !== '0) begin n_fail++; $display("FAIL reset_sweep_valid: got b=%h c=%h expected 0 0", bus_b.out_valid, bus_c.out_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", bus_a.in_ready); end
    endtask

    task automatic test_addressed();
        logic [N_A-1:0] exp_v;
        @(negedge clk);
        idle_all();
        bus_a.sel = SW_A'(5); bus_a.din = 7'h2A; bus_a.in_valid = 1'b1;
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL addr_in_ready: got %b expected 1", bus_a.in_ready); end
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        #1;
        exp_v = '0; exp_v[5] = 1'b1;
        n_tests++; if (bus_a.out_valid !== exp_v) begin n_fail++; $display("FAIL addr_out_valid: got %h expected %h", bus_a.out_valid, exp_v); end
        n_tests++; if (bus_a.dout[5*DW_A +: DW_A] !== 7'h2A) begin n_fail++; $display("FAIL addr_dout5: got %h expected 2a", bus_a.dout[5*DW_A +: DW_A]); end
        @(negedge clk);
        #1;
        n_tests++; if (bus_a.out_valid !== '0) begin n_fail++; $display("FAIL addr_drained: got %h expected 0", bus_a.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [N_A-1:0] exp_v;
        @(negedge clk);
        idle_all();
        bus_a.out_ready[3] = 1'b0;
        bus_a.sel = SW_A'(3); bus_a.din = 7'h11; bus_a.in_valid = 1'b1;
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b expected 1", bus_a.in_ready); end
        @(negedge clk);
        bus_a.din = 7'h22;
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_blocked: got %b expected 0", bus_a.in_ready); end
        n_tests++; if (bus_a.out_valid[3] !== 1'b1 || bus_a.dout[3*DW_A +: DW_A] !== 7'h11) begin n_fail++; $display("FAIL bp_first_held: got v=%b d=%h expected 1 11", bus_a.out_valid[3], bus_a.dout[3*DW_A +: DW_A]); end
        @(negedge clk);
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_blocked: got %b expected 0", bus_a.in_ready); end
        @(negedge clk);
        bus_a.out_ready[3] = 1'b1;
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus_a.in_ready); end
        n_tests++; if (bus_a.dout[3*DW_A +: DW_A] !== 7'h11) begin n_fail++; $display("FAIL bp_first_delivered: got %h expected 11", bus_a.dout[3*DW_A +: DW_A]); end
        @(negedge clk);
        bus_a.in_valid = 1'b0; bus_a.out_ready[3] = 1'b0;
        #1;
        exp_v = '0; exp_v[3] = 1'b1;
        n_tests++; if (bus_a.out_valid !== exp_v || bus_a.dout[3*DW_A +: DW_A] !== 7'h22) begin n_fail++; $display("FAIL bp_second_loaded: got v=%h d=%h expected %h 22", bus_a.out_valid, bus_a.dout[3*DW_A +: DW_A], exp_v); end
        @(negedge clk);
        bus_a.out_ready[3] = 1'b1;
        #1;
        n_tests++; if (bus_a.out_valid[3] !== 1'b1 || bus_a.dout[3*DW_A +: DW_A] !== 7'h22) begin n_fail++; $display("FAIL bp_second_hold: got v=%b d=%h expected 1 22", bus_a.out_valid[3], bus_a.dout[3*DW_A +: DW_A]); end
        @(negedge clk);
        #1;
        n_tests++; if (bus_a.out_valid !== '0) begin n_fail++; $display("FAIL bp_no_duplicate: got %h expected 0", bus_a.out_valid); end
    endtask

    task automatic test_seq_wrap();
        int rd_cnt = 0;
        @(negedge clk);
        idle_all();
        bus_a.out_ready = '0; mode_a = 1'b1; start_a = 1'b1;
        for (int i = 0; i < N_A; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            bus_a.din = DW_A'(i); bus_a.in_valid = 1'b1;
            #1;
            if (round_done_a === 1'b1) rd_cnt++;
            n_tests++; if (ptr_a !== SW_A'(i)) begin n_fail++; $display("FAIL seq_ptr_%0d: got %0d expected %0d", i, ptr_a, i); end
            n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL seq_ready_%0d: got %b expected 1", i, bus_a.in_ready); end
        end
        @(negedge clk);
        bus_a.out_ready[0] = 1'b1; bus_a.din = DW_A'(N_A);
        #1;
        if (round_done_a === 1'b1) rd_cnt++;
        n_tests++; if (bus_a.out_valid !== '1) begin n_fail++; $display("FAIL seq_all_valid: got %h expected all ones", bus_a.out_valid); end
        for (int k = 0; k < N_A; k++) begin
            n_tests++; if (bus_a.dout[k*DW_A +: DW_A] !== DW_A'(k)) begin n_fail++; $display("FAIL seq_ch%0d: got %0d expected %0d", k, bus_a.dout[k*DW_A +: DW_A], k); end
        end
        n_tests++; if (ptr_a !== '0 || bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL seq_wrap_state: got ptr=%0d rdy=%b expected 0 1", ptr_a, bus_a.in_ready); end
        @(negedge clk);
        bus_a.in_valid = 1'b0; bus_a.out_ready[0] = 1'b0;
        #1;
        if (round_done_a === 1'b1) rd_cnt++;
        n_tests++; if (bus_a.dout[0 +: DW_A] !== DW_A'(N_A) || bus_a.out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL seq_ch0_second: got v=%b d=%0d expected 1 %0d", bus_a.out_valid[0], bus_a.dout[0 +: DW_A], N_A); end
        n_tests++; if (ptr_a !== SW_A'(1)) begin n_fail++; $display("FAIL seq_ptr_end: got %0d expected 1", ptr_a); end
        @(negedge clk);
        #1;
        if (round_done_a === 1'b1) rd_cnt++;
        n_tests++; if (rd_cnt !== 1) begin n_fail++; $display("FAIL seq_round_done_count: got %0d expected 1", rd_cnt); end
        @(negedge clk);
        idle_all();
        @(negedge clk);
        #1;
        n_tests++; if (bus_a.out_valid !== '0) begin n_fail++; $display("FAIL seq_drain: got %h expected 0", bus_a.out_valid); end
    endtask

    task automatic test_illegal_sel();
        @(negedge clk);
        idle_all();
        bus_a.sel = SW_A'(30); bus_a.din = 7'h55; bus_a.in_valid = 1'b1;
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b1 || sel_err_a !== 1'b0) begin n_fail++; $display("FAIL ill_accept: got rdy=%b se=%b expected 1 0", bus_a.in_ready, sel_err_a); end
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        #1;
        n_tests++; if (sel_err_a !== 1'b1) begin n_fail++; $display("FAIL ill_sel_err_pulse: got %b expected 1", sel_err_a); end
        n_tests++; if (bus_a.out_valid !== '0) begin n_fail++; $display("FAIL ill_no_valid: got %h expected 0", bus_a.out_valid); end
        @(negedge clk);
        #1;
        n_tests++; if (sel_err_a !== 1'b0 || bus_a.out_valid !== '0) begin n_fail++; $display("FAIL ill_pulse_end: got se=%b v=%h expected 0 0", sel_err_a, bus_a.out_valid); end
    endtask

    task automatic test_start_reset();
        logic [N_A-1:0] exp_v;
        @(negedge clk);
        idle_all();
        bus_a.out_ready = '0; mode_a = 1'b1; start_a = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            bus_a.din = DW_A'(i + 40); bus_a.in_valid = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b1; bus_a.din = 7'h7F;
        #1;
        n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL start_blocks_input: got %b expected 0", bus_a.in_ready); end
        n_tests++; if (ptr_a !== SW_A'(17)) begin n_fail++; $display("FAIL start_ptr_before: got %0d expected 17", ptr_a); end
        @(negedge clk);
        start_a = 1'b0; bus_a.in_valid = 1'b0;
        #1;
        exp_v = '0;
        for (int k = 0; k < 17; k++) exp_v[k] = 1'b1;
        n_tests++; if (ptr_a !== '0) begin n_fail++; $display("FAIL start_ptr_cleared: got %0d expected 0", ptr_a); end
        n_tests++; if (bus_a.out_valid !== exp_v) begin n_fail++; $display("FAIL start_keeps_channels: got %h expected %h", bus_a.out_valid, exp_v); end
        // asynchronous reset in the middle of the low clock phase
        reset_n = 1'b0;
        #1;
        n_tests++; if (bus_a.out_valid !== '0) begin n_fail++; $display("FAIL async_reset_valid: got %h expected 0", bus_a.out_valid); end
        n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready: got %b expected 0", bus_a.in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        idle_all();
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (bus_a.out_valid !== '0) begin n_fail++; $display("FAIL reset_drops_words: got %h expected 0", bus_a.out_valid); end
    endtask

    // Random traffic against a scoreboard: each channel holds at most one
    // pending word; a word leaves when its channel's consumer is ready.
    task automatic test_random();
        logic [SW_A+DW_A-1:0] exp_q[$];
        logic [SW_A+DW_A-1:0] e;
        logic [N_A-1:0]       exp_v;
        logic [DW_A-1:0]      got;
        int  m_ptr = 0;
        int  tgt, ch;
        bit  legal, occ, exp_ready, acc;
        bit  exp_sel_err = 1'b0;
        bit  exp_rd = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (cyc < 1990) begin
                mode_a         = 1'($urandom_range(0, 1));
                start_a        = ($urandom_range(0, 15) == 0);
                bus_a.in_valid = ($urandom_range(0, 3) != 0);
                bus_a.din      = DW_A'($urandom);
                bus_a.sel      = SW_A'($urandom_range(0, 31));
                bus_a.out_ready = N_A'($urandom) | N_A'($urandom);
            end else begin
                idle_all();
            end
            #1;
            tgt   = mode_a ? m_ptr : int'(bus_a.sel);
            legal = (tgt < N_A);
            exp_v = '0;
            occ   = 1'b0;
            foreach (exp_q[i]) begin
                e  = exp_q[i];
                ch = int'(e[SW_A+DW_A-1:DW_A]);
                exp_v[ch] = 1'b1;
                if (ch == tgt) occ = 1'b1;
            end
            exp_ready = start_a ? 1'b0 : (!legal ? 1'b1 : (!occ || bus_a.out_ready[tgt]));
            n_tests++; if (bus_a.in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready cyc=%0d: got %b expected %b", cyc, bus_a.in_ready, exp_ready); end
            n_tests++; if (bus_a.out_valid !== exp_v) begin n_fail++; $display("FAIL rnd_out_valid cyc=%0d: got %h expected %h", cyc, bus_a.out_valid, exp_v); end
            n_tests++; if (ptr_a !== SW_A'(m_ptr)) begin n_fail++; $display("FAIL rnd_ptr cyc=%0d: got %0d expected %0d", cyc, ptr_a, m_ptr); end
            n_tests++; if (sel_err_a !== exp_sel_err) begin n_fail++; $display("FAIL rnd_sel_err cyc=%0d: got %b expected %b", cyc, sel_err_a, exp_sel_err); end
            n_tests++; if (round_done_a !== exp_rd) begin n_fail++; $display("FAIL rnd_round_done cyc=%0d: got %b expected %b", cyc, round_done_a, exp_rd); end
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                e  = exp_q[i];
                ch = int'(e[SW_A+DW_A-1:DW_A]);
                if (bus_a.out_ready[ch]) begin
                    got = bus_a.dout[ch*DW_A +: DW_A];
                    n_tests++; if (got !== e[DW_A-1:0]) begin n_fail++; $display("FAIL rnd_data cyc=%0d ch=%0d: got %h expected %h", cyc, ch, got, e[DW_A-1:0]); end
                    exp_q.delete(i);
                end
            end
            acc = bus_a.in_valid && exp_ready;
            if (acc && legal) exp_q.push_back({SW_A'(tgt), bus_a.din});
            exp_rd      = acc && mode_a && (m_ptr == N_A - 1);
            exp_sel_err = acc && !legal;
            if (start_a) m_ptr = 0;
            else if (acc && mode_a) m_ptr = (m_ptr + 1) % N_A;
        end
        @(negedge clk);
        #1;
        n_tests++; if (exp_q.size() != 0 || bus_a.out_valid !== '0) begin n_fail++; $display("FAIL rnd_final_empty: got q=%0d v=%h expected 0 0", exp_q.size(), bus_a.out_valid); end
    endtask

    task automatic test_sweep_w16_n4();
        int rd_cnt = 0;
        @(negedge clk);
        idle_all();
        bus_b.sel = SW_B'(N_B - 1); bus_b.din = 16'hBEEF; bus_b.in_valid = 1'b1;
        #1;
        n_tests++; if (bus_b.in_ready !== 1'b1) begin n_fail++; $display("FAIL b_addr_ready: got %b expected 1", bus_b.in_ready); end
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        #1;
        n_tests++; if (bus_b.out_valid !== 4'b1000 || bus_b.dout[3*DW_B +: DW_B] !== 16'hBEEF) begin n_fail++; $display("FAIL b_addr_route: got v=%b d=%h expected 1000 beef", bus_b.out_valid, bus_b.dout[3*DW_B +: DW_B]); end
        @(negedge clk);
        bus_b.out_ready = '0; mode_b = 1'b1; start_b = 1'b1;
        for (int i = 0; i < N_B; i++) begin
            @(negedge clk);
            start_b = 1'b0; bus_b.din = DW_B'(i + 100); bus_b.in_valid = 1'b1;
            #1;
            if (round_done_b === 1'b1) rd_cnt++;
            n_tests++; if (ptr_b !== SW_B'(i) || bus_b.in_ready !== 1'b1) begin n_fail++; $display("FAIL b_seq_%0d: got ptr=%0d rdy=%b expected %0d 1", i, ptr_b, bus_b.in_ready, i); end
        end
        @(negedge clk);
        bus_b.out_ready[0] = 1'b1; bus_b.din = DW_B'(N_B + 100);
        #1;
        if (round_done_b === 1'b1) rd_cnt++;
        for (int k = 0; k < N_B; k++) begin
            n_tests++; if (bus_b.dout[k*DW_B +: DW_B] !== DW_B'(k + 100)) begin n_fail++; $display("FAIL b_seq_ch%0d: got %0d expected %0d", k, bus_b.dout[k*DW_B +: DW_B], k + 100); end
        end
        @(negedge clk);
        bus_b.in_valid = 1'b0; bus_b.out_ready = '0;
        #1;
        if (round_done_b === 1'b1) rd_cnt++;
        n_tests++; if (bus_b.dout[0 +: DW_B] !== DW_B'(N_B + 100) || ptr_b !== SW_B'(1)) begin n_fail++; $display("FAIL b_seq_wrap: got d0=%0d ptr=%0d expected %0d 1", bus_b.dout[0 +: DW_B], ptr_b, N_B + 100); end
        @(negedge clk);
        #1;
        if (round_done_b === 1'b1) rd_cnt++;
        n_tests++; if (rd_cnt !== 1) begin n_fail++; $display("FAIL b_round_done_count: got %0d expected 1", rd_cnt); end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_sweep_n2();
        int rd_cnt = 0;
        @(negedge clk);
        idle_all();
        bus_c.sel = SW_C'(N_C - 1); bus_c.din = 7'h3C; bus_c.in_valid = 1'b1;
        #1;
        n_tests++; if (bus_c.in_ready !== 1'b1) begin n_fail++; $display("FAIL c_addr_ready: got %b expected 1", bus_c.in_ready); end
        @(negedge clk);
        bus_c.in_valid = 1'b0;
        #1;
        n_tests++; if (bus_c.out_valid !== 2'b10 || bus_c.dout[1*DW_C +: DW_C] !== 7'h3C) begin n_fail++; $display("FAIL c_addr_route: got v=%b d=%h expected 10 3c", bus_c.out_valid, bus_c.dout[1*DW_C +: DW_C]); end
        @(negedge clk);
        bus_c.out_ready = '0; mode_c = 1'b1; start_c = 1'b1;
        for (int i = 0; i < N_C; i++) begin
            @(negedge clk);
            start_c = 1'b0; bus_c.din = DW_C'(i + 20); bus_c.in_valid = 1'b1;
            #1;
            if (round_done_c === 1'b1) rd_cnt++;
            n_tests++; if (ptr_c !== SW_C'(i) || bus_c.in_ready !== 1'b1) begin n_fail++; $display("FAIL c_seq_%0d: got ptr=%0d rdy=%b expected %0d 1", i, ptr_c, bus_c.in_ready, i); end
        end
        @(negedge clk);
        bus_c.out_ready[0] = 1'b1; bus_c.din = DW_C'(N_C + 20);
        #1;
        if (round_done_c === 1'b1) rd_cnt++;
        for (int k = 0; k < N_C; k++) begin
            n_tests++; if (bus_c.dout[k*DW_C +: DW_C] !== DW_C'(k + 20)) begin n_fail++; $display("FAIL c_seq_ch%0d: got %0d expected %0d", k, bus_c.dout[k*DW_C +: DW_C], k + 20); end
        end
        @(negedge clk);
        bus_c.in_valid = 1'b0; bus_c.out_ready = '0;
        #1;
        if (round_done_c === 1'b1) rd_cnt++;
        n_tests++; if (bus_c.dout[0 +: DW_C] !== DW_C'(N_C + 20) || ptr_c !== SW_C'(1)) begin n_fail++; $display("FAIL c_seq_wrap: got d0=%0d ptr=%0d expected %0d 1", bus_c.dout[0 +: DW_C], ptr_c, N_C + 20); end
        @(negedge clk);
        #1;
        if (round_done_c === 1'b1) rd_cnt++;
        n_tests++; if (rd_cnt !== 1) begin n_fail++; $display("FAIL c_round_done_count: got %0d expected 1", rd_cnt); end
        @(negedge clk);
        idle_all();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_addressed();
        test_back_to_back();
        test_seq_wrap();
        test_illegal_sel();
        test_start_reset();
        test_random();
        test_sweep_w16_n4();
        test_sweep_n2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the end of the test sequence");
        $fatal(1, "timeout");
    end

endmodule
